// File: rtl/vec_mem_pkg.sv
// Shared types and constants for the vector-prefetch memory responder.
// Struct field widths cover MEM_WORDS up to 65536 and LATENCY up to 255.
package vec_mem_pkg;

  localparam int PKG_ADDR_W = 40;
  localparam int PKG_DATA_W = 64;
  localparam int PKG_TID_W  = 6;
  localparam int PKG_IDX_W  = 16;
  localparam int PKG_AGE_W  = 8;

  typedef logic [PKG_ADDR_W-1:0] paddr_t;
  typedef logic [PKG_DATA_W-1:0] data_t;
  typedef logic [PKG_TID_W-1:0]  tid_t;
  typedef logic [PKG_IDX_W-1:0]  word_idx_t;

  typedef struct packed {
    tid_t                 tid;
    word_idx_t            idx;
    logic                 bad;
    logic [PKG_AGE_W-1:0] age;
  } req_entry_t;

  localparam data_t MEM_POISON = 64'hDEAD_BEEF_DEAD_BEEF;

  // Fibonacci feedback taps 16,14,13,11 as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/vec_mem_req_fifo.sv
// In-order queue of accepted read requests; every entry's age counts up each
// cycle and saturates at LATENCY so the head can be retired once it is old enough.
module vec_mem_req_fifo
  import vec_mem_pkg::*;
#(
  parameter int QDEPTH  = 8,
  parameter int LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  req_entry_t                push_entry,
  input  logic                      pop,
  output req_entry_t                head,
  output logic [$clog2(QDEPTH):0]   count
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PKG_AGE_W-1:0] AGE_MAX = PKG_AGE_W'(LATENCY);

  logic [PW:0] wr_ptr_reg;
  logic [PW:0] rd_ptr_reg;
  req_entry_t  entry_reg [QDEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Stale slots keep aging too; a push always rewrites the age to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) entry_reg[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (push && (wr_ptr_reg[PW-1:0] == PW'(i))) begin
          entry_reg[i] <= push_entry;
        end else if (entry_reg[i].age < AGE_MAX) begin
          entry_reg[i].age <= entry_reg[i].age + 1'b1;
        end
      end
    end
  end

  assign head  = entry_reg[rd_ptr_reg[PW-1:0]];
  assign count = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/vec_mem_responder.sv
// Fixed-latency, in-order memory responder with a backdoor-loadable word array.
// Optional VEC_MEM_RESP_STALL_EN adds LFSR-driven pop stalls for latency jitter.
module vec_mem_responder
  import vec_mem_pkg::*;
#(
  parameter int               ADDR_W    = 40,
  parameter int               DATA_W    = 64,
  parameter int               TID_W     = 6,
  parameter int               MEM_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000,
  parameter int               LATENCY   = 4,
  parameter int               QDEPTH    = 8,
  parameter logic [15:0]      LFSR_SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_req_val,
  output logic                         mem_req_rdy,
  input  logic [TID_W-1:0]             mem_req_transid,
  input  logic [ADDR_W-1:0]            mem_req_addr,
  output logic                         mem_resp_val,
  output logic [TID_W-1:0]             mem_resp_transid,
  output logic [DATA_W-1:0]            mem_resp_data,
  input  logic                         bd_wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_wr_idx,
  input  logic [DATA_W-1:0]            bd_wr_data,
  output logic [$clog2(QDEPTH):0]      outstanding,
  output logic                         addr_err
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int QW = $clog2(QDEPTH) + 1;
  localparam logic [ADDR_W-1:0] WIN_LAST =
    BASE_ADDR + ADDR_W'(8 * MEM_WORDS) - ADDR_W'(1);

  logic              rdy_en_reg;
  logic              resp_val_reg;
  logic [TID_W-1:0]  resp_tid_reg;
  logic [DATA_W-1:0] resp_data_reg;
  logic              addr_err_reg;
  logic [DATA_W-1:0] mem_array [MEM_WORDS];

  logic              push;
  logic              pop;
  logic              stall;
  logic              req_bad;
  logic [ADDR_W-1:0] offset;
  req_entry_t        push_entry;
  req_entry_t        head;
  logic [QW-1:0]     count;

  assign offset  = mem_req_addr - BASE_ADDR;
  assign req_bad = (mem_req_addr < BASE_ADDR) || (mem_req_addr > WIN_LAST) ||
                   (mem_req_addr[2:0] != 3'b000);

  always_comb begin
    push_entry     = '0;
    push_entry.tid = tid_t'(mem_req_transid);
    push_entry.idx = word_idx_t'(offset[IW+2:3]);
    push_entry.bad = req_bad;
  end

  assign mem_req_rdy = rdy_en_reg && (count != QW'(QDEPTH));
  assign push        = mem_req_val && mem_req_rdy;
  assign pop         = (count != '0) && (head.age >= PKG_AGE_W'(LATENCY - 1)) && !stall;

  vec_mem_req_fifo #(
    .QDEPTH  (QDEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

`ifdef VEC_MEM_RESP_STALL_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_reg <= LFSR_SEED;
    else        lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
  end

  assign stall = lfsr_reg[0];
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign stall       = 1'b0;
`endif

  // Backing store is never reset; contents persist across rst_n.
  always_ff @(posedge clk) begin
    if (bd_wr_en) mem_array[bd_wr_idx] <= bd_wr_data;
  end

  // A backdoor write landing on the pop edge is not seen: the read takes the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_reg    <= 1'b0;
      resp_val_reg  <= 1'b0;
      resp_tid_reg  <= '0;
      resp_data_reg <= '0;
      addr_err_reg  <= 1'b0;
    end else begin
      rdy_en_reg   <= 1'b1;
      resp_val_reg <= pop;
      if (pop) begin
        resp_tid_reg  <= TID_W'(head.tid);
        resp_data_reg <= head.bad ? DATA_W'(MEM_POISON) : mem_array[head.idx[IW-1:0]];
      end
      if (push && req_bad) addr_err_reg <= 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{head.idx, head.age, offset};

  assign mem_resp_val     = resp_val_reg;
  assign mem_resp_transid = resp_tid_reg;
  assign mem_resp_data    = resp_data_reg;
  assign outstanding      = count;
  assign addr_err         = addr_err_reg;

endmodule

// File: tb/tb_vec_mem_responder.sv
// Scoreboard bench for vec_mem_responder: expectations queued at accept,
// compared by a response monitor on the falling edge.
module tb_vec_mem_responder;

  localparam int LAT = 10;
  localparam int QD  = 8;
  localparam logic [63:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_val = 1'b0;
  logic        mem_req_rdy;
  logic [5:0]  mem_req_transid = '0;
  logic [39:0] mem_req_addr = '0;
  logic        mem_resp_val;
  logic [5:0]  mem_resp_transid;
  logic [63:0] mem_resp_data;
  logic        bd_wr_en = 1'b0;
  logic [7:0]  bd_wr_idx = '0;
  logic [63:0] bd_wr_data = '0;
  logic [3:0]  outstanding;
  logic        addr_err;

  always #5 clk = ~clk;

  vec_mem_responder #(.LATENCY(LAT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_req_val      (mem_req_val),
    .mem_req_rdy      (mem_req_rdy),
    .mem_req_transid  (mem_req_transid),
    .mem_req_addr     (mem_req_addr),
    .mem_resp_val     (mem_resp_val),
    .mem_resp_transid (mem_resp_transid),
    .mem_resp_data    (mem_resp_data),
    .bd_wr_en         (bd_wr_en),
    .bd_wr_idx        (bd_wr_idx),
    .bd_wr_data       (bd_wr_data),
    .outstanding      (outstanding),
    .addr_err         (addr_err)
  );

  typedef struct {
    logic [5:0]  tid;
    logic [63:0] data;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [5:0]  exp_tid = '0;
  logic [63:0] exp_data = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          max_out = 0;
  bit          saw_full = 0;
  bit          inv_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Accept monitor: the expectation set by the driver is queued at the handshake edge.
  always @(posedge clk) begin
    if (rst_n && mem_req_val && mem_req_rdy)
      exp_q.push_back('{tid: exp_tid, data: exp_data, acc: cyc + 1});
  end

  always @(negedge clk) begin
    if (inv_en) begin
      check("outstanding_le_qdepth", 64'(outstanding <= QD), 64'd1);
      check("rdy_vs_outstanding", 64'(mem_req_rdy), 64'(outstanding != QD));
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      if (!mem_req_rdy) saw_full = 1;
    end
    if (mem_resp_val) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got tid %0d data %h expected no response",
                 mem_resp_transid, mem_resp_data);
      end else begin
        e = exp_q.pop_front();
        $display("resp tid=%0d data=%h latency=%0d", mem_resp_transid, mem_resp_data, cyc - e.acc);
        check("resp_tid", 64'(mem_resp_transid), 64'(e.tid));
        check("resp_data", mem_resp_data, e.data);
`ifdef VEC_MEM_RESP_STALL_EN
        check("resp_latency_min", 64'((cyc - e.acc) >= LAT), 64'd1);
`else
        check("resp_latency", 64'(cyc - e.acc), 64'(LAT));
`endif
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [5:0] tid, input logic [39:0] addr, input logic [63:0] data);
    int guard = 0;
    mem_req_val     = 1'b1;
    mem_req_transid = tid;
    mem_req_addr    = addr;
    exp_tid         = tid;
    exp_data        = data;
    @(negedge clk);
    while (!mem_req_rdy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!mem_req_rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got rdy 0 for tid %0d expected rdy 1", tid);
      mem_req_val = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    mem_req_val = 1'b0;
  endtask

  task automatic bd_write(input logic [7:0] idx, input logic [63:0] data);
    bd_wr_en   = 1'b1;
    bd_wr_idx  = idx;
    bd_wr_data = data;
    @(posedge clk);
    #1;
    bd_wr_en = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", 64'(mem_req_rdy), 64'd0);
    check("reset_resp_val", 64'(mem_resp_val), 64'd0);
    check("reset_transid", 64'(mem_resp_transid), 64'd0);
    check("reset_data", mem_resp_data, 64'd0);
    check("reset_outstanding", 64'(outstanding), 64'd0);
    check("reset_addr_err", 64'(addr_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rdy_after_reset", 64'(mem_req_rdy), 64'd1);
    inv_en = 1;

    for (int i = 0; i < 16; i++) bd_write(8'(i), 64'h11 * (i + 1));
    bd_write(8'd255, 64'hFFEE);

    // 1: single read of word 0
    send(6'd0, 40'h1000, 64'h11);
    drain();

    // 2: back-to-back stream fills the queue
    max_out  = 0;
    saw_full = 0;
    for (int i = 0; i < 16; i++) send(6'(i), 40'h1000 + 40'(8 * i), 64'h11 * (i + 1));
    drain();
    check("stream_max_outstanding", 64'(max_out), 64'(QD));
    check("stream_rdy_dropped", 64'(saw_full), 64'd1);
    check("addr_err_clean", 64'(addr_err), 64'd0);

    // 3: window edges and misalignment
    send(6'd20, 40'h0FF8, POISON);
    send(6'd21, 40'h1804, POISON);
    send(6'd22, 40'h17F8, 64'hFFEE);
    send(6'd23, 40'h1800, POISON);
    drain();
    check("addr_err_set", 64'(addr_err), 64'd1);

`ifndef VEC_MEM_RESP_STALL_EN
    // 4: backdoor write on the pop edge returns old data
    send(6'd30, 40'h1010, 64'h33);
    repeat (LAT - 1) @(posedge clk);
    #1;
    bd_write(8'd2, 64'hAA);
    drain();
    send(6'd31, 40'h1010, 64'hAA);
    drain();
`endif
    check("addr_err_sticky", 64'(addr_err), 64'd1);

    // 5: reset with requests in flight
    for (int i = 0; i < 5; i++) send(6'(40 + i), 40'h1000 + 40'(8 * i), 64'h11 * (i + 1));
    check("outstanding_before_reset", 64'(outstanding), 64'd5);
    inv_en = 0;
    rst_n  = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_outstanding", 64'(outstanding), 64'd0);
    check("midreset_rdy", 64'(mem_req_rdy), 64'd0);
    check("midreset_addr_err", 64'(addr_err), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 15) @(posedge clk);
    #1;
    check("post_reset_rdy", 64'(mem_req_rdy), 64'd1);
    check("post_reset_outstanding", 64'(outstanding), 64'd0);
    check("post_reset_resp_val", 64'(mem_resp_val), 64'd0);
    inv_en = 1;

`ifdef VEC_MEM_RESP_STALL_EN
    // 6: stalled pops keep order and never beat LATENCY
    for (int i = 0; i < 64; i++) send(6'(i), 40'h1000 + 40'(8 * (i % 16)), 64'h11 * ((i % 16) + 1));
    drain();
`endif

    send(6'd63, 40'h1008, 64'h22);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
